// File: rtl/multicycle_addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM state and op encodings.
package multicycle_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multicycle_addsub_rca.sv
// W-bit ripple-carry adder with carry in, built from a chain of full-adder cells.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module chunk_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[W];
endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice per cycle, carry rippled through a flop,
// valid/ready on both sides, carry/overflow/zero flags captured on completion.
module multicycle_addsub
    import multicycle_addsub_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         cout,
    output logic         overflow,
    output logic         zero
);
    localparam int NCHUNK = (CHUNK >= 1) ? N / CHUNK : 1;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad_chunk
        $error("multicycle_addsub: CHUNK must be >= 1 and divide N");
    end

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [N-1:0]      opa_q, opa_d;
    logic [N-1:0]      opb_q, opb_d;
    logic [N-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
    logic              c_sl;

    // A single shared adder; the operand slices are selected by the chunk index.
    assign a_sl = opa_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_sl = opb_q[int'(idx_q) * CHUNK +: CHUNK];

    chunk_rca #(.W(CHUNK)) u_rca (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d    = a;
                    opb_d    = (sub == OP_SUB) ? ~b : b;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q) * CHUNK +: CHUNK] = s_sl;
                carry_d = c_sl;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = c_sl;
                    zero_d  = (result_d == '0);
                    // opb_q already holds ~b for subtraction, so one rule covers both ops.
                    ovf_d   = (opa_q[N-1] == opb_q[N-1]) & (s_sl[CHUNK-1] != opa_q[N-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed and model-checked bench for multicycle_addsub (CHUNK=8 main instance, CHUNK=32 latency instance).
module tb_multicycle_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        cout, overflow, zero;

    logic        f_in_valid, f_in_ready, f_out_valid, f_cout, f_overflow, f_zero;
    logic [31:0] f_result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_addsub #(.N(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    multicycle_addsub #(.N(32), .CHUNK(32)) u_dut_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (f_out_valid),
        .out_ready (1'b1),
        .result    (f_result),
        .cout      (f_cout),
        .overflow  (f_overflow),
        .zero      (f_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and waits for out_valid; lat counts edges from the accept edge.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input bit rnd_ready, input bit release_out,
                         output logic [31:0] res, output logic c, output logic ov,
                         output logic z, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        res = result; c = cout; ov = overflow; z = zero;
        if (release_out) begin
            out_ready = 1'b1;
            guard = 0;
            while (out_valid && guard < 100) begin
                step();
                guard++;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        c, ov, z;
        int          lat;
        logic [31:0] held;
        logic [32:0] model;
        logic [31:0] ra, rb, rbm;
        logic        rs, mov;

        rst_n = 1'b0; in_valid = 1'b0; f_in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        step(); step();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_flags", {result, cout, overflow, zero}, '0);
        rst_n = 1'b1;
        step();

        do_op(32'h000000FF, 32'h1, 1'b0, 0, 1, r, c, ov, z, lat);
        check_eq("t1_res", r, 32'h100);
        check_eq("t1_flags", {c, ov, z}, 3'b000);
        check_eq("t1_latency", lat, 4);

        do_op(32'h7FFFFFFF, 32'h1, 1'b0, 0, 1, r, c, ov, z, lat);
        check_eq("t2_ovf_res", r, 32'h80000000);
        check_eq("t2_ovf_flags", {c, ov, z}, 3'b010);
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 0, 1, r, c, ov, z, lat);
        check_eq("t2_wrap_res", r, 32'h0);
        check_eq("t2_wrap_flags", {c, ov, z}, 3'b101);

        do_op(32'h5, 32'h5, 1'b1, 0, 1, r, c, ov, z, lat);
        check_eq("t3_eq_res", r, 32'h0);
        check_eq("t3_eq_flags", {c, ov, z}, 3'b101);
        do_op(32'h0, 32'h1, 1'b1, 0, 1, r, c, ov, z, lat);
        check_eq("t3_borrow_res", r, 32'hFFFFFFFF);
        check_eq("t3_borrow_flags", {c, ov, z}, 3'b000);
        do_op(32'h80000000, 32'h1, 1'b1, 0, 1, r, c, ov, z, lat);
        check_eq("t3_ovf_res", r, 32'h7FFFFFFF);
        check_eq("t3_ovf_flags", {c, ov, z}, 3'b110);

        // Backpressure: hold DONE while a producer pulses in_valid with other operands.
        out_ready = 1'b0;
        do_op(32'h12345678, 32'h11111111, 1'b0, 0, 0, r, c, ov, z, lat);
        check_eq("t4_res", r, 32'h23456789);
        held = r;
        for (int i = 0; i < 3; i++) begin
            a = 32'hDEAD0000 + 32'(i); b = 32'h1; in_valid = (i != 1);
            step();
            check_eq("t4_hold_res", {result, cout, overflow, zero}, {held, 3'b000});
            check_eq("t4_hold_rdy", {in_ready, out_valid}, 2'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("t4_release", {in_ready, out_valid}, 2'b10);

        // Reset in the middle of RUN abandons the op.
        a = 32'hAAAA5555; b = 32'h1; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        check_eq("t5_rst", {out_valid, in_ready, result}, {2'b01, 32'h0});
        rst_n = 1'b1;
        step();
        check_eq("t5_no_late_valid", out_valid, 0);
        do_op(32'd3, 32'd4, 1'b0, 0, 1, r, c, ov, z, lat);
        check_eq("t5_res", {c, r}, {1'b0, 32'd7});

        // Full-width instance completes in a single cycle.
        a = 32'h7FFFFFFF; b = 32'h1; sub = 1'b0; f_in_valid = 1'b1;
        step();
        f_in_valid = 1'b0;
        step();
        check_eq("t6_full_valid", f_out_valid, 1);
        check_eq("t6_full_res", {f_cout, f_overflow, f_zero, f_result}, {3'b010, 32'h80000000});

        for (int k = 0; k < 200; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (k == 0) begin ra = 32'h0; rb = 32'h0; rs = 1'b0; end
            rbm   = rs ? ~rb : rb;
            model = {1'b0, ra} + {1'b0, rbm} + 33'(rs);
            mov   = (ra[31] == rbm[31]) && (model[31] != ra[31]);
            do_op(ra, rb, rs, 1, 1, r, c, ov, z, lat);
            check_eq("rnd_sum", {c, r}, model);
            check_eq("rnd_flags", {ov, z}, {mov, model[31:0] == 32'h0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
